// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Holds the sequencing state enum and the two sysid word addresses.
package sysid_pkg;

    localparam int   SYSID_DATA_W  = 32;
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        LAT_ID,
        REQ_TS,
        LAT_TS,
        EVAL,
        DONE
    } state_e;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the sysid slave.
interface sysid_boot_checker_if;
    import sysid_pkg::*;

    logic                    avm_address;
    logic                    avm_read;
    logic                    avm_waitrequest;
    logic [SYSID_DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/sysid_boot_checker_avm_single_read.sv
// One Avalon-MM word read: holds the request through waitrequest (with timeout),
// then counts fixed read latency and flags the cycle readdata is valid.
module avm_single_read
    import sysid_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_i,
    input  logic                    lat_i,
    input  logic                    addr_i,
    sysid_boot_checker_if.master    avm,
    output logic                    accept_o,
    output logic                    timeout_o,
    output logic                    capture_o,
    output logic [SYSID_DATA_W-1:0] data_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        lat_q, lat_d;

    // NOTE: every output of a combinational block gets a default on every path, otherwise a latch is inferred.
    always_comb begin
        avm.avm_read    = req_i;
        avm.avm_address = req_i ? addr_i : 1'b0;
        data_o          = avm.avm_readdata;
        accept_o        = req_i && !avm.avm_waitrequest;
        // The held cycle that reaches the limit is the last one with the strobe up.
        timeout_o       = req_i && avm.avm_waitrequest
                          && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
        capture_o       = lat_i && (lat_q == 2'(READ_LATENCY - 1));
        wait_d          = (req_i && avm.avm_waitrequest) ? wait_q + 1'b1 : '0;
        lat_d           = (lat_i && !capture_o) ? lat_q + 1'b1 : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_q <= '0;
            lat_q  <= '0;
        end else begin
            wait_q <= wait_d;
            lat_q  <= lat_d;
        end
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid check: reads ID and timestamp words, compares them against the
// build parameters with bounded retries, and publishes the verdict flags.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'h54F5_12BF,
    parameter bit                      CHECK_TS       = 1'b1,
    parameter int                      READ_LATENCY   = 1,
    parameter int                      TIMEOUT_CYCLES = 255,
    parameter int                      MAX_RETRIES    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_i,
    sysid_boot_checker_if.master    avm,
    output logic [SYSID_DATA_W-1:0] id_value_o,
    output logic [SYSID_DATA_W-1:0] ts_value_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    id_ok_o,
    output logic                    ts_ok_o,
    output logic                    timeout_o,
    output logic [1:0]              attempts_o
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4 || MAX_RETRIES < 0 || MAX_RETRIES > 2) begin : g_bad_param
        $error("sysid_boot_checker: READ_LATENCY must be 1..4 and MAX_RETRIES 0..2");
    end

    state_e                  state_q, state_d;
    logic                    auto_q;
    logic                    to_q, to_d;
    logic [1:0]              attempts_q, attempts_d;
    logic [SYSID_DATA_W-1:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
    logic                    id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;

    logic                    rd_req, rd_lat, rd_addr;
    logic                    rd_accept, rd_timeout, rd_capture;
    logic [SYSID_DATA_W-1:0] rd_data;
    logic                    id_match, ts_match;

    avm_single_read #(
        .READ_LATENCY  (READ_LATENCY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_read (
        .clock    (clock),
        .reset    (reset),
        .req_i    (rd_req),
        .lat_i    (rd_lat),
        .addr_i   (rd_addr),
        .avm      (avm),
        .accept_o (rd_accept),
        .timeout_o(rd_timeout),
        .capture_o(rd_capture),
        .data_o   (rd_data)
    );

    // A timed-out attempt fails both comparisons, even with a captured ID word.
    assign id_match = !to_q && (id_value_q == EXPECTED_ID);
    assign ts_match = !to_q && (!CHECK_TS || (ts_value_q == EXPECTED_TS));

    always_comb begin
        state_d    = state_q;
        to_d       = to_q;
        attempts_d = attempts_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        rd_req     = 1'b0;
        rd_lat     = 1'b0;
        rd_addr    = SYSID_ADDR_ID;
        unique case (state_q)
            IDLE: if (start_i || auto_q) begin
                attempts_d = '0;
                to_d       = 1'b0;
                state_d    = REQ_ID;
            end
            REQ_ID, REQ_TS: begin
                rd_req  = 1'b1;
                rd_addr = (state_q == REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
                if (rd_accept) begin
                    state_d = (state_q == REQ_TS) ? LAT_TS : LAT_ID;
                end else if (rd_timeout) begin
                    to_d    = 1'b1;
                    state_d = EVAL;
                end
            end
            LAT_ID: begin
                rd_lat = 1'b1;
                if (rd_capture) begin
                    id_value_d = rd_data;
                    state_d    = REQ_TS;
                end
            end
            LAT_TS: begin
                rd_lat = 1'b1;
                if (rd_capture) begin
                    ts_value_d = rd_data;
                    state_d    = EVAL;
                end
            end
            EVAL: begin
                attempts_d = (attempts_q == 2'd3) ? attempts_q : attempts_q + 2'd1;
                if (!(id_match && ts_match) && (int'(attempts_q) < MAX_RETRIES)) begin
                    to_d    = 1'b0;
                    state_d = REQ_ID;
                end else begin
                    // Verdict lands on the same edge as DONE so it is valid alongside done.
                    id_ok_d   = id_match;
                    ts_ok_d   = ts_match;
                    timeout_d = to_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            auto_q     <= 1'b1;
            to_q       <= 1'b0;
            attempts_q <= '0;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            auto_q     <= 1'b0;
            to_q       <= to_d;
            attempts_q <= attempts_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign id_value_o = id_value_q;
    assign ts_value_o = ts_value_q;
    assign id_ok_o    = id_ok_q;
    assign ts_ok_o    = ts_ok_q;
    assign timeout_o  = timeout_q;
    assign attempts_o = attempts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: three checker instances (default, short timeout, long latency)
// each facing a small sysid slave model with configurable stalls and bad timestamps.
module tb_sysid_boot_checker;
    import sysid_pkg::*;

    localparam logic [31:0] ID_WORD = 32'h0000_0000;
    localparam logic [31:0] TS_GOOD = 32'h54F5_12BF;
    localparam logic [31:0] TS_BAD  = 32'h54F5_12BE;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int wr_hold [3];
    int bad_n   [3];

    sysid_boot_checker_if bus [3] ();

    logic [31:0] id_value_w [3];
    logic [31:0] ts_value_w [3];
    logic        busy_w     [3];
    logic        done_w     [3];
    logic        id_ok_w    [3];
    logic        ts_ok_w    [3];
    logic        timeout_w  [3];
    logic [1:0]  attempts_w [3];

    sysid_boot_checker u_dut0 (
        .clock(clock), .reset(reset), .start_i(start), .avm(bus[0]),
        .id_value_o(id_value_w[0]), .ts_value_o(ts_value_w[0]), .busy_o(busy_w[0]),
        .done_o(done_w[0]), .id_ok_o(id_ok_w[0]), .ts_ok_o(ts_ok_w[0]),
        .timeout_o(timeout_w[0]), .attempts_o(attempts_w[0])
    );

    sysid_boot_checker #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(0)) u_dut1 (
        .clock(clock), .reset(reset), .start_i(start), .avm(bus[1]),
        .id_value_o(id_value_w[1]), .ts_value_o(ts_value_w[1]), .busy_o(busy_w[1]),
        .done_o(done_w[1]), .id_ok_o(id_ok_w[1]), .ts_ok_o(ts_ok_w[1]),
        .timeout_o(timeout_w[1]), .attempts_o(attempts_w[1])
    );

    sysid_boot_checker #(.READ_LATENCY(3)) u_dut2 (
        .clock(clock), .reset(reset), .start_i(start), .avm(bus[2]),
        .id_value_o(id_value_w[2]), .ts_value_o(ts_value_w[2]), .busy_o(busy_w[2]),
        .done_o(done_w[2]), .id_ok_o(id_ok_w[2]), .ts_ok_o(ts_ok_w[2]),
        .timeout_o(timeout_w[2]), .attempts_o(attempts_w[2])
    );

    for (genvar g = 0; g < 3; g++) begin : g_slv
        localparam int LAT = (g == 2) ? 3 : 1;
        int   held     = 0;
        int   lat_left = 0;
        int   ts_cnt   = 0;
        logic paddr    = 1'b0;
        int   cyc      = 0;
        int   done_at  = -1;
        int   done_cnt = 0;
        int   rd_cnt   = 0;

        // Slave: stalls wr_hold cycles per read, returns data exactly LAT cycles after accept.
        always @(posedge clock) begin
            if (reset) begin
                held     <= 0;
                lat_left <= 0;
                ts_cnt   <= 0;
            end else begin
                held <= (bus[g].avm_read && bus[g].avm_waitrequest) ? held + 1 : 0;
                if (bus[g].avm_read && !bus[g].avm_waitrequest) begin
                    lat_left <= LAT;
                    paddr    <= bus[g].avm_address;
                end else if (lat_left > 0) begin
                    lat_left <= lat_left - 1;
                end
                if (lat_left == 1 && paddr) ts_cnt <= ts_cnt + 1;
            end
        end

        assign bus[g].avm_waitrequest = bus[g].avm_read && (held < wr_hold[g]);
        assign bus[g].avm_readdata    = (lat_left != 1) ? JUNK :
                                        (!paddr ? ID_WORD : ((ts_cnt < bad_n[g]) ? TS_BAD : TS_GOOD));

        // Monitor: cycle 0 is the first cycle after reset release.
        always @(negedge clock) begin
            if (reset) begin
                cyc      <= 0;
                done_at  <= -1;
                done_cnt <= 0;
                rd_cnt   <= 0;
            end else begin
                cyc <= cyc + 1;
                if (bus[g].avm_read) rd_cnt <= rd_cnt + 1;
                if (done_w[g]) begin
                    done_at  <= cyc;
                    done_cnt <= done_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        wr_hold = '{0, 1000, 2};
        bad_n   = '{0, 0, 0};

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_read",     bus[0].avm_read, 0);
        check("rst_address",  bus[0].avm_address, 0);
        check("rst_busy",     busy_w[0], 0);
        check("rst_done",     done_w[0], 0);
        check("rst_flags",    {id_ok_w[0], ts_ok_w[0], timeout_w[0]}, 0);
        check("rst_attempts", attempts_w[0], 0);
        check("rst_values",   id_value_w[0] | ts_value_w[0], 0);

        // Run 1: clean pass on dut0, timeout on dut1, stalled long-latency pass on dut2.
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (40) @(negedge clock);
        check("pass_done_at",   g_slv[0].done_at, 6);
        check("pass_done_cnt",  g_slv[0].done_cnt, 1);
        check("pass_id_ok",     id_ok_w[0], 1);
        check("pass_ts_ok",     ts_ok_w[0], 1);
        check("pass_timeout",   timeout_w[0], 0);
        check("pass_attempts",  attempts_w[0], 1);
        check("pass_ts_value",  ts_value_w[0], TS_GOOD);
        check("pass_id_value",  id_value_w[0], ID_WORD);
        check("pass_busy_idle", busy_w[0], 0);
        check("to_done_at",     g_slv[1].done_at, 10);
        check("to_read_cycles", g_slv[1].rd_cnt, 8);
        check("to_timeout",     timeout_w[1], 1);
        check("to_id_ok",       id_ok_w[1], 0);
        check("to_ts_ok",       ts_ok_w[1], 0);
        check("to_attempts",    attempts_w[1], 1);
        check("lat3_done_at",   g_slv[2].done_at, 14);
        check("lat3_id_value",  id_value_w[2], ID_WORD);
        check("lat3_ts_value",  ts_value_w[2], TS_GOOD);
        check("lat3_ok",        {id_ok_w[2], ts_ok_w[2], timeout_w[2]}, 3'b110);

        // Run 2: timestamp always wrong, retries exhausted.
        bad_n[0] = 100;
        do_reset();
        repeat (40) @(negedge clock);
        check("bad_done_at",  g_slv[0].done_at, 16);
        check("bad_done_cnt", g_slv[0].done_cnt, 1);
        check("bad_ts_ok",    ts_ok_w[0], 0);
        check("bad_id_ok",    id_ok_w[0], 1);
        check("bad_attempts", attempts_w[0], 3);
        check("bad_ts_value", ts_value_w[0], TS_BAD);

        // Run 3: timestamp wrong on the first attempt only.
        bad_n[0] = 1;
        do_reset();
        repeat (40) @(negedge clock);
        check("retry_done_at",  g_slv[0].done_at, 11);
        check("retry_ts_ok",    ts_ok_w[0], 1);
        check("retry_attempts", attempts_w[0], 2);
        check("retry_ts_value", ts_value_w[0], TS_GOOD);

        // Run 4: start re-run, reset during LAT_TS, then start while busy.
        bad_n[0] = 0;
        do_reset();
        repeat (30) @(negedge clock);
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("lat_ts_busy", busy_w[0], 1);
        check("lat_ts_read", bus[0].avm_read, 0);
        check("lat_ts_flags_kept", {id_ok_w[0], ts_ok_w[0]}, 2'b11);
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_read",     bus[0].avm_read, 0);
        check("mid_rst_busy",     busy_w[0], 0);
        check("mid_rst_flags",    {id_ok_w[0], ts_ok_w[0], timeout_w[0]}, 0);
        check("mid_rst_attempts", attempts_w[0], 0);
        check("mid_rst_id_value", id_value_w[0], 0);
        check("mid_rst_ts_value", ts_value_w[0], 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (30) @(negedge clock);
        check("rerun_done_cnt", g_slv[0].done_cnt, 1);
        check("rerun_done_at",  g_slv[0].done_at, 6);
        check("rerun_ok",       {id_ok_w[0], ts_ok_w[0], timeout_w[0]}, 3'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
